// File: rtl/pc_stack.sv
// Program-counter stack for the fetch stage: one active PC per call level, DEPTH levels.
// Optional macro PC_STACK_REL_EN adds pc_rel for PC-relative set/call targets.
module pc_stack #(
   parameter int PC_W  = 9,
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pc_inc,
   input  logic             pc_set,
   input  logic             pc_call,
   input  logic             pc_ret,
`ifdef PC_STACK_REL_EN
   input  logic             pc_rel,
`endif
   input  logic [PC_W-1:0]  pc_set_value,
   input  logic             err_clr,
   output logic [PC_W-1:0]  pc_out,
   output logic [PTR_W-1:0] level,
   output logic             full,
   output logic             empty,
   output logic             ovf,
   output logic             unf,
   output logic             err
);

   localparam logic [PTR_W-1:0] LAST_LEVEL = PTR_W'(DEPTH - 1);

   logic [PC_W-1:0] slot [DEPTH];
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pc_next_seq;

   assign pc_out      = slot[level];
   assign pc_next_seq = pc_out + PC_W'(1);
   assign full        = (level == LAST_LEVEL);
   assign empty       = (level == '0);

`ifdef PC_STACK_REL_EN
   // Adding the raw value modulo 2**PC_W is the same as adding its sign-extended form.
   assign target = pc_rel ? (pc_out + pc_set_value) : pc_set_value;
`else
   assign target = pc_set_value;
`endif

   // One action per cycle by priority; a new error in the err_clr cycle wins over the clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot[i] <= '0;
         end
         level <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
         err   <= 1'b0;
      end else begin
         if (err_clr) begin
            ovf <= 1'b0;
            unf <= 1'b0;
            err <= 1'b0;
         end
         if (pc_call && pc_ret) begin
            err <= 1'b1;
         end else if (pc_call) begin
            if (full) begin
               ovf <= 1'b1;
               err <= 1'b1;
            end else begin
               slot[level]                 <= pc_next_seq;
               slot[level + PTR_W'(1)]     <= target;
               level                       <= level + PTR_W'(1);
            end
         end else if (pc_ret) begin
            if (empty) begin
               unf <= 1'b1;
               err <= 1'b1;
            end else begin
               level <= level - PTR_W'(1);
            end
         end else if (pc_set) begin
            slot[level] <= target;
         end else if (pc_inc) begin
            slot[level] <= pc_next_seq;
         end
      end
   end

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack (PC_W=9, DEPTH=8); the relative-target
// steps are compiled only when PC_STACK_REL_EN is defined.
module tb_pc_stack;

   localparam int PC_W  = 9;
   localparam int DEPTH = 8;
   localparam int PTR_W = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             pc_inc;
   logic             pc_set;
   logic             pc_call;
   logic             pc_ret;
`ifdef PC_STACK_REL_EN
   logic             pc_rel;
`endif
   logic [PC_W-1:0]  pc_set_value;
   logic             err_clr;
   logic [PC_W-1:0]  pc_out;
   logic [PTR_W-1:0] level;
   logic             full;
   logic             empty;
   logic             ovf;
   logic             unf;
   logic             err;

   int vectors     = 0;
   int miscompares = 0;

   pc_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_inc       (pc_inc),
      .pc_set       (pc_set),
      .pc_call      (pc_call),
      .pc_ret       (pc_ret),
`ifdef PC_STACK_REL_EN
      .pc_rel       (pc_rel),
`endif
      .pc_set_value (pc_set_value),
      .err_clr      (err_clr),
      .pc_out       (pc_out),
      .level        (level),
      .full         (full),
      .empty        (empty),
      .ovf          (ovf),
      .unf          (unf),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      rst_n        = 1'b1;
      pc_inc       = 1'b0;
      pc_set       = 1'b0;
      pc_call      = 1'b0;
      pc_ret       = 1'b0;
`ifdef PC_STACK_REL_EN
      pc_rel       = 1'b0;
`endif
      pc_set_value = '0;
      err_clr      = 1'b0;
   endtask

   // Apply the currently driven inputs for one edge, sample 1 time unit later, then idle.
   task automatic tick();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic check_state(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_level,
                              input logic exp_full, input logic exp_empty, input logic exp_ovf,
                              input logic exp_unf, input logic exp_err);
      check({tag, ".pc"},    32'(pc_out), exp_pc);
      check({tag, ".level"}, 32'(level),  exp_level);
      check({tag, ".full"},  32'(full),   32'(exp_full));
      check({tag, ".empty"}, 32'(empty),  32'(exp_empty));
      check({tag, ".ovf"},   32'(ovf),    32'(exp_ovf));
      check({tag, ".unf"},   32'(unf),    32'(exp_unf));
      check({tag, ".err"},   32'(err),    32'(exp_err));
   endtask

   initial begin
      idle_inputs();
      @(negedge clk);

      // 1: reset then three increments
      rst_n = 1'b0; pc_inc = 1'b1; tick();
      check_state("reset", 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         pc_inc = 1'b1; tick();
      end
      check_state("inc3", 3, 0, 0, 1, 0, 0, 0);

      // 2: call, two increments, return
      pc_call = 1'b1; pc_set_value = 9'h040; tick();
      check_state("call40", 9'h040, 1, 0, 0, 0, 0, 0);
      pc_inc = 1'b1; tick();
      pc_inc = 1'b1; tick();
      check("call40.inc2.pc", 32'(pc_out), 9'h042);
      pc_ret = 1'b1; tick();
      check_state("ret1", 4, 0, 0, 1, 0, 0, 0);

      // 3: fill the stack, overflow, clear
      for (int i = 0; i < DEPTH - 1; i++) begin
         pc_call = 1'b1; pc_set_value = PC_W'(9'h100 + i); tick();
      end
      check_state("fill", 9'h106, 7, 1, 0, 0, 0, 0);
      pc_call = 1'b1; pc_set_value = 9'h055; tick();
      check_state("ovf", 9'h106, 7, 1, 0, 1, 0, 1);
      err_clr = 1'b1; tick();
      check_state("clr_ovf", 9'h106, 7, 1, 0, 0, 0, 0);
      pc_call = 1'b1; err_clr = 1'b1; tick();
      check_state("ovf_vs_clr", 9'h106, 7, 1, 0, 1, 0, 1);
      err_clr = 1'b1; tick();
      pc_ret = 1'b1; tick();
      check_state("ret_from_full", 9'h106, 6, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH - 2; i++) begin
         pc_ret = 1'b1; tick();
      end
      check_state("unwind", 5, 0, 0, 1, 0, 0, 0);

      // 4: underflow and illegal call+ret
      pc_ret = 1'b1; tick();
      check_state("unf", 5, 0, 0, 1, 0, 1, 1);
      err_clr = 1'b1; tick();
      check_state("clr_unf", 5, 0, 0, 1, 0, 0, 0);
      pc_call = 1'b1; pc_ret = 1'b1; pc_set_value = 9'h0AA; tick();
      check_state("illegal", 5, 0, 0, 1, 0, 0, 1);
      err_clr = 1'b1; tick();
      check("clr_illegal.err", 32'(err), 0);

      // Call/ret take priority over inc/set in the same cycle
      pc_call = 1'b1; pc_inc = 1'b1; pc_set_value = 9'h020; tick();
      check_state("call_with_inc", 9'h020, 1, 0, 0, 0, 0, 0);
      pc_ret = 1'b1; pc_set = 1'b1; pc_set_value = 9'h077; tick();
      check_state("ret_with_set", 6, 0, 0, 1, 0, 0, 0);

      // 5: set beats inc, then wrap at 2**PC_W-1
      pc_set = 1'b1; pc_inc = 1'b1; pc_set_value = 9'h1FF; tick();
      check("set_over_inc.pc", 32'(pc_out), 9'h1FF);
      pc_inc = 1'b1; tick();
      check_state("wrap", 0, 0, 0, 1, 0, 0, 0);
      pc_set = 1'b1; pc_set_value = 9'h0AB; tick();
      check("set_ab.pc", 32'(pc_out), 9'h0AB);

`ifdef PC_STACK_REL_EN
      // 6a: relative targets
      pc_set = 1'b1; pc_set_value = 9'h010; tick();
      pc_set = 1'b1; pc_rel = 1'b1; pc_set_value = 9'h1FE; tick();
      check("rel_set.pc", 32'(pc_out), 9'h00E);
      pc_call = 1'b1; pc_rel = 1'b1; pc_set_value = 9'h005; tick();
      check_state("rel_call", 9'h013, 1, 0, 0, 0, 0, 0);
      pc_ret = 1'b1; tick();
      check("rel_call.ret.pc", 32'(pc_out), 9'h00F);
`endif

      // 6: reset in the middle of nesting with flags set
      for (int i = 0; i < 3; i++) begin
         pc_call = 1'b1; pc_set_value = PC_W'(9'h150 + i); tick();
      end
      pc_call = 1'b1; pc_ret = 1'b1; tick();
      check_state("nest3", 9'h152, 3, 0, 0, 0, 0, 1);
      rst_n = 1'b0; pc_call = 1'b1; pc_set_value = 9'h033; tick();
      check_state("mid_reset", 0, 0, 0, 1, 0, 0, 0);
      pc_call = 1'b1; pc_set_value = 9'h033; tick();
      pc_ret = 1'b1; tick();
      check_state("slot0_cleared", 1, 0, 0, 1, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
